matrix_alu: RTL

// Memory-mapped matrix arithmetic unit sitting directly downstream of the execution engine on
// the shared address/nRead/nWrite bus in the 16'h2000 window. Engine writes two 4x4 operands,

---
 rtl/matrix_alu.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/matrix_alu.sv
// Memory-mapped 4x4 matrix unit on the engine bus: two operands, a command strobe, one result.
// Multiply runs one result row per cycle; add, subtract and transpose finish in a single cycle.
module matrix_alu #(
   parameter int          ELEM_W    = 16,
   parameter int          DIM       = 4,
   parameter logic [9:0]  BASE_ADDR = 10'h080
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [15:0]               address,
   input  logic                      nRead,
   input  logic                      nWrite,
   input  logic [DIM*DIM*ELEM_W-1:0] ExeDataOut,
   output logic [DIM*DIM*ELEM_W-1:0] MatrixDataOut,
   output logic                      MatrixBusy
);
   localparam int DATA_W = DIM*DIM*ELEM_W;
   localparam int CNT_W  = (DIM > 1) ? $clog2(DIM) : 1;

   localparam logic [1:0] U_MUL = 2'd0;
   localparam logic [1:0] U_ADD = 2'd1;
   localparam logic [1:0] U_SUB = 2'd2;

   localparam logic [1:0] OFS_OPA = 2'd0;
   localparam logic [1:0] OFS_OPB = 2'd1;
   localparam logic [1:0] OFS_RES = 2'd2;
   localparam logic [1:0] OFS_CMD = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL} state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  opa_q, opa_d;
   logic [DATA_W-1:0]  opb_q, opb_d;
   logic [DATA_W-1:0]  res_q, res_d;
   logic [DATA_W-1:0]  rd_q, rd_d;
   logic [CNT_W-1:0]   row_q, row_d;
   logic [1:0]         unit_q, unit_d;
   logic               cmd_prev_q, cmd_prev_d;

   logic               hit, cmd_match, busy, accept;
   logic [1:0]         unit, offset;
   logic [DATA_W-1:0]  res_alu;
   logic [DIM*ELEM_W-1:0] mul_row;
   logic [ELEM_W-1:0]  el_a, el_b, el_t, acc;

   always_comb begin
      hit       = (address[15:6] == BASE_ADDR);
      unit      = address[5:4];
      offset    = address[1:0];
      cmd_match = hit && (offset == OFS_CMD) && nRead && nWrite;
      busy      = (state_q != ST_IDLE);
      // Only the first cycle of a held command address counts as a new command.
      accept    = cmd_match && !cmd_prev_q && !busy;
   end

   // Element-wise results for the single-cycle units, selected by the latched unit.
   always_comb begin
      res_alu = '0;
      el_a    = '0;
      el_b    = '0;
      el_t    = '0;
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            el_a = opa_q[ELEM_W*(DIM*i+j) +: ELEM_W];
            el_b = opb_q[ELEM_W*(DIM*i+j) +: ELEM_W];
            el_t = opa_q[ELEM_W*(DIM*j+i) +: ELEM_W];
            case (unit_q)
               U_ADD:   res_alu[ELEM_W*(DIM*i+j) +: ELEM_W] = el_a + el_b;
               U_SUB:   res_alu[ELEM_W*(DIM*i+j) +: ELEM_W] = el_a - el_b;
               default: res_alu[ELEM_W*(DIM*i+j) +: ELEM_W] = el_t;
            endcase
         end
      end
   end

   // One row of OPA*OPB, the row chosen by the multiply counter.
   always_comb begin
      mul_row = '0;
      acc     = '0;
      for (int j = 0; j < DIM; j++) begin
         acc = '0;
         for (int k = 0; k < DIM; k++) begin
            acc = acc + opa_q[ELEM_W*(DIM*int'(row_q)+k) +: ELEM_W]
                      * opb_q[ELEM_W*(DIM*k+j) +: ELEM_W];
         end
         mul_row[ELEM_W*j +: ELEM_W] = acc;
      end
   end

   always_comb begin
      state_d    = state_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      res_d      = res_q;
      row_d      = row_q;
      unit_d     = unit_q;
      cmd_prev_d = cmd_match;
      rd_d       = '0;

      if (hit && !nWrite && !busy && offset == OFS_OPA) opa_d = ExeDataOut;
      if (hit && !nWrite && !busy && offset == OFS_OPB) opb_d = ExeDataOut;
      // A simultaneous write wins; the read returns zero.
      if (hit && !nRead && nWrite && offset == OFS_RES) rd_d = res_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               unit_d  = unit;
               row_d   = '0;
               state_d = (unit == U_MUL) ? ST_MUL : ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_d   = res_alu;
            state_d = ST_IDLE;
         end
         ST_MUL: begin
            res_d[DIM*ELEM_W*int'(row_q) +: DIM*ELEM_W] = mul_row;
            if (int'(row_q) == DIM-1) begin
               row_d   = '0;
               state_d = ST_IDLE;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         opa_q      <= '0;
         opb_q      <= '0;
         res_q      <= '0;
         rd_q       <= '0;
         row_q      <= '0;
         unit_q     <= '0;
         cmd_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         res_q      <= res_d;
         rd_q       <= rd_d;
         row_q      <= row_d;
         unit_q     <= unit_d;
         cmd_prev_q <= cmd_prev_d;
      end
   end

   assign MatrixDataOut = rd_q;
   assign MatrixBusy    = busy;
endmodule
